// File: rtl/flex_fifo_pkg.sv
// Shared definitions for flex_fifo: read-mode constants, the flag bundle and
// a constant-evaluable ceil(log2) helper used to size pointers and the count.
package flex_fifo_pkg;

    localparam int unsigned FWFT_OFF = 0;
    localparam int unsigned FWFT_ON  = 1;

    // Occupancy-derived status flags, kept together so they update as one
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        longint unsigned span;
        result = 0;
        span   = 1;
        while (span < longint'(value)) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/flex_fifo_mem.sv
// Storage array for flex_fifo: DEPTH x WIDTH, synchronous write, asynchronous read.
// Ports:
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write address (0..DEPTH-1)
//   wdata_i  - write data
//   raddr_i  - read address (0..DEPTH-1)
//   rdata_c  - combinational read data
module flex_fifo_mem
    import flex_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_c
);

    // Contents are intentionally not reset
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/flex_fifo.sv
// Synchronous FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds and a choice of registered-read or first-word-fall-through output.
// Ports:
//   clk          - clock, all state changes on rising edge
//   reset        - asynchronous active-high reset
//   data_in      - write data
//   wr           - write request
//   rd           - read request (pop request in FWFT mode)
//   data_out     - read data (registered)
//   full/empty   - occupancy == DEPTH / == 0
//   almost_full  - occupancy >= AF_LEVEL
//   almost_empty - occupancy <= AE_LEVEL
//   count        - occupancy 0..DEPTH
//   overflow     - one-cycle pulse after a rejected write
//   underflow    - one-cycle pulse after a rejected read
module flex_fifo
    import flex_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned DEPTH    = 16,
    parameter  int unsigned AF_LEVEL = DEPTH - 2,
    parameter  int unsigned AE_LEVEL = 2,
    parameter  int unsigned FWFT     = FWFT_OFF,
    localparam int unsigned CW       = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = clog2(DEPTH);

    // Elaboration-time parameter legality
    if (WIDTH < 1 || DEPTH < 2 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH ||
        (FWFT != FWFT_OFF && FWFT != FWFT_ON)) begin : g_bad_params
        $fatal(1, "flex_fifo: illegal parameter set");
    end

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    fifo_flags_t      flags_q,  flags_d;
    logic [WIDTH-1:0] dout_q,   dout_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;

    logic             wr_acc;
    logic             rd_acc;
    logic [PW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    // Pointer advance with explicit wrap for non-power-of-two depths
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    function automatic fifo_flags_t decode_flags(input logic [CW-1:0] occ);
        fifo_flags_t f;
        f.full         = (occ == CW'(DEPTH));
        f.empty        = (occ == '0);
        f.almost_full  = (occ >= CW'(AF_LEVEL));
        f.almost_empty = (occ <= CW'(AE_LEVEL));
        return f;
    endfunction

    flex_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (mem_raddr),
        .rdata_c (mem_rdata)
    );

    // Acceptance, pointer/count update and next output word
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dout_d    = dout_q;
        mem_raddr = rd_ptr_q;

        // A full FIFO is never empty, so a concurrent read always frees a slot
        rd_acc = rd && !flags_q.empty;
        wr_acc = wr && (!flags_q.full || rd);

        if (wr_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_acc) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (FWFT == FWFT_ON) begin
            // Preload the head for next cycle; when the new head is the word
            // being written right now it is not yet in memory, so bypass it.
            mem_raddr = rd_ptr_d;
            if (wr_acc && (rd_ptr_d == wr_ptr_q)) begin
                dout_d = data_in;
            end else begin
                dout_d = mem_rdata;
            end
        end else if (rd_acc) begin
            dout_d = mem_rdata;
        end

        // Registered flags track the registered count exactly
        flags_d = decode_flags(count_d);
        ovf_d   = wr && !wr_acc;
        unf_d   = rd && flags_q.empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= decode_flags('0);
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign data_out     = dout_q;
    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.almost_full;
    assign almost_empty = flags_q.almost_empty;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
